// File: rtl/ival_rx_pkg.sv
// Shared types and width helpers for the ival serial receiver.
package ival_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DEF_STAT_W  = 10;
  localparam int DEF_BIT_CYC = 8;
  localparam int DEF_DEB_CYC = 2;

  // Bit timer counts down from BIT_CYC-1, so it needs clog2(BIT_CYC) bits.
  function automatic int tmr_w(input int bit_cyc);
    return (bit_cyc < 2) ? 1 : $clog2(bit_cyc);
  endfunction

  // Bit counter must hold values 0..STAT_W.
  function automatic int cnt_w(input int stat_w);
    return $clog2(stat_w + 1);
  endfunction

endpackage

// File: rtl/ival_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
module ival_debounce #(
  parameter int DEB_CYC = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic ival,
  output logic value
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] cnt;

  // cnt tracks how many cycles sync_2 has already disagreed with value;
  // the level is accepted on the DEB_CYC-th disagreeing cycle.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      cnt    <= '0;
      value  <= 1'b1;
    end else begin
      sync_1 <= ival;
      sync_2 <= sync_1;
      if (sync_2 != value) begin
        if (cnt == DEB_LAST) begin
          value <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ival_rx.sv
// Start/data/stop deframer on the debounced ival line with a one-entry
// valid/ready output register.
module ival_rx
  import ival_rx_pkg::*;
#(
  parameter int STAT_W  = DEF_STAT_W,
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              ival,
  input  logic              enable,
  input  logic              rdy,
  output logic [STAT_W-1:0] status_o,
  output logic              dv,
  output logic              value,
  output logic              busy,
  output logic              ferr,
  output logic              ovf
);

  // Handshake: a word is transferred on every cycle where dv and rdy are both
  // high; dv holds with status_o stable until then, and a new word may be
  // loaded on the same edge as a transfer.

  localparam int TW = tmr_w(BIT_CYC);
  localparam int CW = cnt_w(STAT_W);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CYC / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CYC - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(STAT_W - 1);

  rx_state_t         state, state_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic [CW-1:0]     bcnt, bcnt_nxt;
  logic [STAT_W-1:0] sr, sr_nxt;
  logic              value_d;
  logic              deliver;
  logic              stop_err;

  ival_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_debounce (
    .sysclk(sysclk),
    .reset (reset),
    .ival  (ival),
    .value (value)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      bcnt    <= '0;
      sr      <= '0;
      value_d <= 1'b1;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      bcnt    <= bcnt_nxt;
      sr      <= sr_nxt;
      value_d <= value;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    bcnt_nxt  = bcnt;
    sr_nxt    = sr;
    deliver   = 1'b0;
    stop_err  = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      tmr_nxt   = '0;
      bcnt_nxt  = '0;
      sr_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Only a genuine 1->0 edge starts a frame, so a line still low
          // after a bad stop bit cannot retrigger.
          if (value_d && !value) begin
            state_nxt = ST_START;
            tmr_nxt   = HALF_LOAD;
          end
        end
        ST_START: begin
          if (tmr == '0) begin
            if (!value) begin
              state_nxt = ST_SHIFT;
              tmr_nxt   = FULL_LOAD;
              bcnt_nxt  = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (tmr == '0) begin
            sr_nxt   = {value, sr[STAT_W-1:1]};
            bcnt_nxt = bcnt + 1'b1;
            tmr_nxt  = FULL_LOAD;
            if (bcnt == LAST_BIT) state_nxt = ST_STOP;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        ST_STOP: begin
          if (tmr == '0) begin
            state_nxt = ST_IDLE;
            if (value) deliver  = 1'b1;
            else       stop_err = 1'b1;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      status_o <= '0;
      dv       <= 1'b0;
      ovf      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      ferr <= stop_err;
      if (deliver && (!dv || rdy)) begin
        status_o <= sr;
        dv       <= 1'b1;
      end else begin
        if (deliver) ovf <= 1'b1;
        if (dv && rdy) dv <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ival_rx.sv
// Bench for ival_rx: vector table, hand-timed corner cases and random frames.
module tb_ival_rx;

  localparam int STAT_W  = 10;
  localparam int BIT_CYC = 8;
  localparam int DEB_CYC = 2;
  localparam int LAT     = 2 + DEB_CYC;

  logic              sysclk;
  logic              reset;
  logic              ival;
  logic              enable;
  logic              rdy;
  logic [STAT_W-1:0] status_o;
  logic              dv;
  logic              value;
  logic              busy;
  logic              ferr;
  logic              ovf;

  int n_cmp  = 0;
  int n_fail = 0;
  int dv_cyc = 0;
  int ferr_cyc = 0;
  int xfer_cnt = 0;
  bit sb_on = 1'b0;
  logic [STAT_W-1:0] exp_q[$];

  typedef struct {
    logic [STAT_W-1:0] data;
    logic              stop;
    logic [STAT_W-1:0] exp_status;
    int                exp_dv;
    int                exp_ferr;
  } vec_t;

  vec_t vecs[6];

  ival_rx #(
    .STAT_W (STAT_W),
    .BIT_CYC(BIT_CYC),
    .DEB_CYC(DEB_CYC)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .ival    (ival),
    .enable  (enable),
    .rdy     (rdy),
    .status_o(status_o),
    .dv      (dv),
    .value   (value),
    .busy    (busy),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  // Clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: all input changes happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [STAT_W-1:0] data, input logic stop, input int gap);
    ival = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < STAT_W; i++) begin
      ival = data[i];
      tick(BIT_CYC);
    end
    ival = stop;
    tick(BIT_CYC);
    ival = 1'b1;
    tick(gap);
  endtask

  // Monitor and scoreboard
  always @(negedge sysclk) begin
    if (reset) begin
      if (dv) dv_cyc++;
      if (ferr) ferr_cyc++;
      if (dv && rdy) begin
        xfer_cnt++;
        if (sb_on) begin
          if (exp_q.size() == 0) check("sb_unexpected_word", 32'(status_o), 32'hFFFF_FFFF);
          else check("sb_word", 32'(status_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int d0, f0, x0, exp_ferr_rand;
    logic [STAT_W-1:0] rw;
    logic rs;

    vecs[0] = '{10'h2A5, 1'b1, 10'h2A5, 1, 0};
    vecs[1] = '{10'h155, 1'b0, 10'h2A5, 0, 1};
    vecs[2] = '{10'h000, 1'b1, 10'h000, 1, 0};
    vecs[3] = '{10'h3FF, 1'b1, 10'h3FF, 1, 0};
    vecs[4] = '{10'h0F0, 1'b0, 10'h3FF, 0, 1};
    vecs[5] = '{10'h201, 1'b1, 10'h201, 1, 0};

    reset = 1'b0; ival = 1'b1; enable = 1'b1; rdy = 1'b1;
    tick(3);
    check("rst_status", 32'(status_o), 0);
    check("rst_dv", 32'(dv), 0);
    check("rst_value", 32'(value), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ferr", 32'(ferr), 0);
    check("rst_ovf", 32'(ovf), 0);
    reset = 1'b1;
    tick(5);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      d0 = dv_cyc; f0 = ferr_cyc;
      send_frame(vecs[v].data, vecs[v].stop, 16);
      @(negedge sysclk);
      check($sformatf("vec%0d_dv_cycles", v), 32'(dv_cyc - d0), 32'(vecs[v].exp_dv));
      check($sformatf("vec%0d_ferr_cycles", v), 32'(ferr_cyc - f0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_status", v), 32'(status_o), 32'(vecs[v].exp_status));
      check($sformatf("vec%0d_ovf", v), 32'(ovf), 0);
      tick(1);
    end

    // 1-cycle glitch: filtered out entirely
    ival = 1'b0;
    tick(1);
    ival = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge sysclk);
      check($sformatf("glitch_value_c%0d", c), 32'(value), 1);
      check($sformatf("glitch_busy_c%0d", c), 32'(busy), 0);
      tick(0);
      @(posedge sysclk); #1;
    end
    tick(5);

    // 3-cycle low pulse: value falls LAT after the fall, START one later,
    // false start detected BIT_CYC/2 after entering START.
    d0 = dv_cyc; f0 = ferr_cyc;
    ival = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge sysclk); #1;
      if (c == 3) ival = 1'b1;
      @(negedge sysclk);
      check($sformatf("pulse_value_c%0d", c), 32'(value),
            32'((c >= LAT && c < 3 + LAT) ? 0 : 1));
      check($sformatf("pulse_busy_c%0d", c), 32'(busy),
            32'((c >= LAT + 1 && c < LAT + 1 + BIT_CYC / 2) ? 1 : 0));
    end
    tick(10);
    check("pulse_no_dv", 32'(dv_cyc - d0), 0);
    check("pulse_no_ferr", 32'(ferr_cyc - f0), 0);

    // Overrun with rdy low
    rdy = 1'b0;
    send_frame(10'h001, 1'b1, 16);
    send_frame(10'h3FF, 1'b1, 16);
    check("ovr_status", 32'(status_o), 32'h001);
    check("ovr_dv", 32'(dv), 1);
    check("ovr_ovf", 32'(ovf), 1);
    rdy = 1'b1;
    tick(1);
    @(negedge sysclk);
    check("ovr_drain_dv", 32'(dv), 0);
    check("ovr_sticky_ovf", 32'(ovf), 1);
    tick(4);

    // Simultaneous load and drain; reset first so ovf starts clear
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
    rdy = 1'b0;
    send_frame(10'h0AA, 1'b1, 16);
    check("sim_first_status", 32'(status_o), 32'h0AA);
    fork
      send_frame(10'h355, 1'b1, 16);
      begin
        // stop sample edge is 1 + LAT + BIT_CYC/2 + (STAT_W+1)*BIT_CYC after the start drive
        tick(LAT + BIT_CYC / 2 + (STAT_W + 1) * BIT_CYC);
        rdy = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check("sim_status", 32'(status_o), 32'h355);
        check("sim_dv", 32'(dv), 1);
        check("sim_ovf", 32'(ovf), 0);
      end
    join
    tick(2);

    // Abort after 5 data bits
    d0 = dv_cyc;
    ival = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < 5; i++) begin
      ival = vecs[0].data[i];
      tick(BIT_CYC);
    end
    tick(2);
    @(negedge sysclk);
    check("abort_busy_before", 32'(busy), 1);
    @(posedge sysclk); #1;
    enable = 1'b0;
    ival = 1'b1;
    @(negedge sysclk);
    check("abort_busy_held", 32'(busy), 1);
    @(posedge sysclk);
    @(negedge sysclk);
    check("abort_idle", 32'(busy), 0);
    tick(5);
    enable = 1'b1;
    tick(120);
    check("abort_no_dv", 32'(dv_cyc - d0), 0);

    // Reset mid-frame
    ival = 1'b0;
    tick(40);
    reset = 1'b0;
    #1;
    check("midrst_status", 32'(status_o), 0);
    check("midrst_dv", 32'(dv), 0);
    check("midrst_value", 32'(value), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ferr", 32'(ferr), 0);
    check("midrst_ovf", 32'(ovf), 0);
    ival = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(10);
    check("postrst_no_dv", 32'(dv), 0);
    d0 = dv_cyc;
    send_frame(10'h0F0, 1'b1, 16);
    check("postrst_status", 32'(status_o), 32'h0F0);
    check("postrst_dv_cycles", 32'(dv_cyc - d0), 1);

    // Random frames against the queue model
    sb_on = 1'b1;
    exp_ferr_rand = 0;
    f0 = ferr_cyc;
    x0 = xfer_cnt;
    for (int n = 0; n < 20; n++) begin
      rw = STAT_W'($urandom_range(0, (1 << STAT_W) - 1));
      rs = ($urandom_range(0, 3) != 0);
      if (rs) exp_q.push_back(rw);
      else exp_ferr_rand++;
      send_frame(rw, rs, 12 + $urandom_range(0, 20));
    end
    tick(10);
    check("rand_queue_empty", 32'(exp_q.size()), 0);
    check("rand_ferr_count", 32'(ferr_cyc - f0), 32'(exp_ferr_rand));
    check("rand_xfer_count", 32'(xfer_cnt - x0), 32'(20 - exp_ferr_rand));
    check("rand_ovf", 32'(ovf), 0);
    sb_on = 1'b0;

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ival_rx.md
# ival_rx

Serial front-end that feeds the status/mux stage. It synchronises and debounces the asynchronous `ival` line, then deframes start/data/stop frames into `STAT_W`-bit status words. Each word is presented with a valid/ready handshake, and the current debounced level is exported as `value`. It sits directly upstream of the status logic, which consumes `status_o`, `dv` and `value`.

## Interface
Parameters:
- `STAT_W`, default 10: data bits per frame, which is also the width of `status_o`.
- `BIT_CYC`, default 8: `sysclk` cycles per bit. Even, ≥4.
- `DEB_CYC`, default 2: consecutive stable cycles required before `value` changes. ≥1.

Ports:
- `sysclk`, input, 1: clock, rising edge.
- `reset`, input, 1: reset, asynchronous, active-low.
- `ival`, input, 1: asynchronous serial line; idles high.
- `enable`, input, 1: receive enable; low aborts any frame in progress.
- `rdy`, input, 1: downstream ready.
- `status_o`, output, `STAT_W`: received word, LSB = first data bit.
- `dv`, output, 1: `status_o` valid.
- `value`, output, 1: debounced line level.
- `busy`, output, 1: FSM not in IDLE.
- `ferr`, output, 1: one-cycle pulse on a stop-bit error.
- `ovf`, output, 1: sticky overrun flag; cleared only by reset.

## Operation
- **Input conditioning**
  - 2-FF synchroniser on `ival`; both flops reset to 1.
  - Debounce counter: `value` takes the synchronised level once that level has differed from `value` for `DEB_CYC` consecutive cycles.
  - Any glitch restarts the count.
- **FSM states:** IDLE, START, SHIFT, STOP.
  - **IDLE:** on a `value` 1→0 transition with `enable`=1, go to START and load the bit timer with `BIT_CYC/2-1`.
  - **START:** when the timer reaches 0, sample `value`.
    - If 0: go to SHIFT, timer = `BIT_CYC-1`, bit count = 0.
    - If 1: false start; go back to IDLE with no flags raised.
  - **SHIFT:** at each timer expiry, shift `value` into the MSB of the shift register (right-shift, so the first bit lands in the LSB) and increment the bit count. After bit `STAT_W-1`, go to STOP with timer = `BIT_CYC-1`.
  - **STOP:** at timer expiry, sample `value`, then return to IDLE.
    - 1: deliver the word (see output register).
    - 0: pulse `ferr` and discard the word.
- **Output register:** one entry.
  - On delivery with `dv`=0, or with `dv`=1 and `rdy`=1 in the same cycle: load `status_o`; `dv`=1.
  - On delivery with `dv`=1 and `rdy`=0: drop the new word, set `ovf`, and leave `status_o` unchanged.
  - Transfer happens on `dv & rdy`; `dv` then clears unless a load occurs in the same cycle.
- **`enable`=0:** the FSM goes to IDLE on the next edge and discards the shift register. The output register, `dv`, `ovf` and debouncing are unaffected.
- **Arithmetic:** the bit timer is `$clog2(BIT_CYC)` bits, decrementing. The bit counter is `$clog2(STAT_W+1)` bits. No wrap-around is possible within a frame.

## Timing
- **Reset values:** `status_o`=0, `dv`=0, `value`=1, `busy`=0, `ferr`=0, `ovf`=0. FSM is in IDLE.
- **Input latency:** a clean edge on `ival` appears on `value` 2+`DEB_CYC` cycles later.
- **Start detection:** START is entered 1 cycle after `value` falls.
- **Sampling points:** the start bit is sampled `BIT_CYC/2` cycles after entering START. Each following sample is `BIT_CYC` cycles after the previous one.
- **Delivery latency:** `dv` rises 1 cycle after the stop-bit sample. The output register is updated on that same edge.
- **`ferr`:** asserted for exactly 1 cycle, on the cycle after the stop-bit sample.
- **`busy`:** high from the edge that enters START until the edge that returns to IDLE.
- **Reset mid-frame:** all state returns immediately to reset values; no partial word is ever delivered.

## Structure
- **Package `ival_rx_pkg`:**
  - state enum type (IDLE, START, SHIFT, STOP);
  - localparam helpers for timer and counter widths.
- **Sub-module `ival_debounce`:** synchroniser plus debounce counter. Inputs `sysclk`, `reset`, `ival`; output `value`; parameter `DEB_CYC`.
- **Top level:** the FSM, shift register and output register stay in `ival_rx`.

## Test plan
All scenarios use `STAT_W`=10, `BIT_CYC`=8, `DEB_CYC`=2, `enable`=1, `rdy`=1 unless noted.
- **Single frame:** send 0x2A5 (start, 10 bits LSB first, stop) → `dv` pulses for 1 cycle with `status_o`=0x2A5; `ferr`=0, `ovf`=0.
- **Glitch and false start:**
  - a 1-cycle low glitch on an idle line → `value` stays 1, `busy` stays 0;
  - a 3-cycle low pulse → START entered, then back to IDLE; no `dv`, no `ferr`.
- **Stop-bit error:** frame 0x155 with stop bit 0 → one-cycle `ferr`, `dv` stays 0, `status_o` unchanged.
- **Overrun:** with `rdy`=0, send 0x001 then 0x3FF → `status_o`=0x001, `dv`=1, `ovf`=1. Raise `rdy` → `dv` clears, `ovf` stays 1.
- **Simultaneous load and drain:** `rdy` rises on the exact cycle the second word is delivered → `status_o` = second word, `dv` stays 1, `ovf`=0.
- **Abort and reset:**
  - drop `enable` after 5 data bits → IDLE next cycle, no `dv`;
  - assert `reset` low mid-frame → all outputs at reset values immediately;
  - after release, a clean frame 0x0F0 is received correctly.
